// File: rtl/tag_free_list_if.sv
// tag_free_list_if: alloc/free handshake bundle between the tag free list and its users.
//   master: consumer/producer side (drives alloc_valid, free_valid, free_tag)
//   slave : free list side (drives alloc_ready, alloc_tag, free_count, err_double_free)
interface tag_free_list_if #(
    parameter int TAG_W = 4
);
    logic             alloc_valid;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic             free_valid;
    logic [TAG_W-1:0] free_tag;
    logic [TAG_W:0]   free_count;
    logic             err_double_free;

    modport master (
        output alloc_valid, free_valid, free_tag,
        input  alloc_ready, alloc_tag, free_count, err_double_free
    );

    modport slave (
        input  alloc_valid, free_valid, free_tag,
        output alloc_ready, alloc_tag, free_count, err_double_free
    );
endinterface

// File: rtl/tag_free_list.sv
// tag_free_list: circular FIFO of free physical tags with a bitmap shadow for double-free detection.
//   clk                  rising-edge clock
//   rst_aL               synchronous active-low reset; refills the list with tags 0..N-1
//   bus.alloc_valid      consumer takes the head tag this cycle (only when alloc_ready)
//   bus.alloc_ready      a free tag is available
//   bus.alloc_tag        tag at the FIFO head
//   bus.free_valid       producer returns bus.free_tag this cycle (no backpressure)
//   bus.free_tag         tag being released
//   bus.free_count       number of free tags, 0..N
//   bus.err_double_free  sticky flag: a tag that was already free was released again
module tag_free_list #(
    parameter int TAG_W = 4
) (
    input logic            clk,
    input logic            rst_aL,
    tag_free_list_if.slave bus
);
    localparam int N = 1 << TAG_W;

    logic [TAG_W-1:0] mem_q [N];
    logic [TAG_W-1:0] mem_d [N];
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;
    logic [N-1:0]     free_map_q, free_map_d;
    logic             err_q, err_d;
    logic             alloc_fire;
    logic             good_free;

    always_comb begin
        alloc_fire = bus.alloc_valid & (count_q != '0);
        // The bitmap is checked against pre-cycle state, so freeing the tag being
        // allocated this same cycle counts as a double free.
        good_free  = bus.free_valid & ~free_map_q[bus.free_tag];
        mem_d      = mem_q;
        head_d     = head_q;
        tail_d     = tail_q;
        free_map_d = free_map_q;
        err_d      = err_q | (bus.free_valid & ~good_free);
        if (alloc_fire) begin
            head_d                    = head_q + 1'b1;
            free_map_d[mem_q[head_q]] = 1'b0;
        end
        // A good free always names an allocated tag, so it never collides with the
        // bitmap bit cleared by a same-cycle alloc.
        if (good_free) begin
            mem_d[tail_q]            = bus.free_tag;
            tail_d                   = tail_q + 1'b1;
            free_map_d[bus.free_tag] = 1'b1;
        end
        count_d = count_q + (TAG_W+1)'(good_free) - (TAG_W+1)'(alloc_fire);
    end

    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            for (int i = 0; i < N; i++) mem_q[i] <= TAG_W'(i);
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= (TAG_W+1)'(N);
            free_map_q <= '1;
            err_q      <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            free_map_q <= free_map_d;
            err_q      <= err_d;
        end
    end

    // Outputs come straight from registers; no input reaches an output in the same cycle.
    assign bus.alloc_ready     = count_q != '0;
    assign bus.alloc_tag       = mem_q[head_q];
    assign bus.free_count      = count_q;
    assign bus.err_double_free = err_q;

    a_count_matches_map: assert property (@(posedge clk) disable iff (!rst_aL)
        count_q == (TAG_W+1)'($countones(free_map_q)));
endmodule

// File: tb/tb_tag_free_list.sv
// tb_tag_free_list: table vectors, hand sequences and random traffic checked against a queue model.
module tb_tag_free_list;
    logic clk;
    logic rst_aL;
    int   errors = 0;
    int   checks = 0;

    tag_free_list_if #(.TAG_W(4)) bus ();

    tag_free_list #(.TAG_W(4)) dut (
        .clk    (clk),
        .rst_aL (rst_aL),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int q[$];
    bit mfree[16];
    bit merr;

    typedef struct {
        bit av;
        bit fv;
        int ft;
        bit rdy;
        int tag;
        int cnt;
        bit err;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    function automatic void mreset();
        q.delete();
        for (int i = 0; i < 16; i++) begin
            q.push_back(i);
            mfree[i] = 1'b1;
        end
        merr = 1'b0;
    endfunction

    function automatic void mstep(input bit av, input bit fv, input int ft);
        bit fire;
        bit good;
        fire = av && q.size() > 0;
        good = fv && !mfree[ft];
        if (fire) begin
            mfree[q[0]] = 1'b0;
            void'(q.pop_front());
        end
        if (good) begin
            q.push_back(ft);
            mfree[ft] = 1'b1;
        end
        if (fv && !good) merr = 1'b1;
    endfunction

    task automatic cmp_model();
        chk("model_ready", int'(bus.alloc_ready), int'(q.size() != 0));
        if (q.size() != 0) chk("model_tag", int'(bus.alloc_tag), q[0]);
        chk("model_count", int'(bus.free_count), q.size());
        chk("model_err", int'(bus.err_double_free), int'(merr));
    endtask

    task automatic cyc(input bit rn, input bit av, input bit fv, input int ft);
        rst_aL          = rn;
        bus.alloc_valid = av;
        bus.free_valid  = fv;
        bus.free_tag    = 4'(ft);
        @(posedge clk);
        if (!rn) mreset();
        else mstep(av, fv, ft);
        #1;
        cmp_model();
    endtask

    initial begin
        int seen[16];
        int pick[$];
        int prev;
        bit have_prev;
        rst_aL          = 1'b0;
        bus.alloc_valid = 1'b0;
        bus.free_valid  = 1'b0;
        bus.free_tag    = '0;
        tbl = '{
            '{1, 1, 7,  1, 7,  1, 0},
            '{0, 1, 3,  1, 7,  2, 0},
            '{0, 1, 12, 1, 7,  3, 0},
            '{1, 0, 0,  1, 3,  2, 0},
            '{1, 0, 0,  1, 12, 1, 0},
            '{1, 0, 0,  0, 0,  0, 0},
            '{0, 1, 1,  1, 1,  1, 0},
            '{0, 1, 2,  1, 1,  2, 0},
            '{0, 1, 3,  1, 1,  3, 0},
            '{0, 1, 4,  1, 1,  4, 0},
            '{0, 1, 5,  1, 1,  5, 0},
            '{1, 1, 9,  1, 2,  5, 0},
            '{1, 0, 0,  1, 3,  4, 0},
            '{1, 0, 0,  1, 4,  3, 0},
            '{1, 0, 0,  1, 5,  2, 0},
            '{1, 0, 0,  1, 9,  1, 0},
            '{1, 0, 0,  0, 0,  0, 0}
        };

        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("reset_ready", int'(bus.alloc_ready), 1);
        chk("reset_tag", int'(bus.alloc_tag), 0);
        chk("reset_count", int'(bus.free_count), 16);
        chk("reset_err", int'(bus.err_double_free), 0);

        for (int i = 0; i < 16; i++) begin
            chk("drain_tag", int'(bus.alloc_tag), i);
            cyc(1, 1, 0, 0);
        end
        chk("drain_ready", int'(bus.alloc_ready), 0);
        chk("drain_count", int'(bus.free_count), 0);

        for (int i = 0; i < 17; i++) begin
            cyc(1, tbl[i].av, tbl[i].fv, tbl[i].ft);
            chk($sformatf("vec%0d_ready", i), int'(bus.alloc_ready), int'(tbl[i].rdy));
            if (tbl[i].rdy) chk($sformatf("vec%0d_tag", i), int'(bus.alloc_tag), tbl[i].tag);
            chk($sformatf("vec%0d_count", i), int'(bus.free_count), tbl[i].cnt);
            chk($sformatf("vec%0d_err", i), int'(bus.err_double_free), int'(tbl[i].err));
        end

        cyc(0, 0, 0, 0);
        cyc(1, 0, 1, 5);
        chk("dbl_err", int'(bus.err_double_free), 1);
        chk("dbl_count", int'(bus.free_count), 16);
        cyc(1, 0, 0, 0);
        chk("dbl_sticky", int'(bus.err_double_free), 1);

        cyc(0, 0, 0, 0);
        cyc(1, 1, 1, 0);
        chk("head_free_err", int'(bus.err_double_free), 1);
        chk("head_free_count", int'(bus.free_count), 15);
        chk("head_free_tag", int'(bus.alloc_tag), 1);

        cyc(0, 0, 0, 0);
        for (int i = 0; i < 14; i++) cyc(1, 1, 0, 0);
        chk("pre_rst_count", int'(bus.free_count), 2);
        cyc(0, 1, 0, 0);
        chk("mid_rst_count", int'(bus.free_count), 16);
        chk("mid_rst_tag", int'(bus.alloc_tag), 0);
        chk("mid_rst_err", int'(bus.err_double_free), 0);

        cyc(0, 0, 0, 0);
        have_prev = 1'b0;
        prev = 0;
        for (int k = 0; k < 40; k++) begin
            if (k % 16 == 0) for (int i = 0; i < 16; i++) seen[i] = 0;
            chk("wrap_tag", int'(bus.alloc_tag), k % 16);
            seen[k % 16]++;
            chk("wrap_once", seen[int'(bus.alloc_tag)], 1);
            prev = int'(bus.alloc_tag);
            cyc(1, 1, have_prev, have_prev ? (k + 15) % 16 : 0);
            have_prev = 1'b1;
        end
        chk("wrap_err", int'(bus.err_double_free), 0);
        chk("wrap_last", prev, 7);

        cyc(0, 0, 0, 0);
        for (int k = 0; k < 3000; k++) begin
            bit rn;
            bit av;
            bit fv;
            int ft;
            pick.delete();
            for (int i = 0; i < 16; i++) if (!mfree[i]) pick.push_back(i);
            rn = $urandom_range(0, 299) != 0;
            av = $urandom_range(0, 99) < 55;
            fv = $urandom_range(0, 99) < 50;
            if (pick.size() != 0 && $urandom_range(0, 19) != 0)
                ft = pick[$urandom_range(0, pick.size() - 1)];
            else
                ft = $urandom_range(0, 15);
            cyc(rn, av, fv, ft);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
